rvee_trap_ctrl: RTL and testbench

RVEE_TRAP_CTRL -- requirements
Module: rvee_trap_ctrl

---
 rtl/rvee_trap_pkg.sv | 23 ++
 rtl/rvee_trap_target.sv | 46 ++++
 rtl/rvee_trap_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_rvee_trap_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvee_trap_pkg.sv
// Shared types and constants for the trap sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvee_trap_pkg;

    // Sequencer states: IDLE samples requests, ENTRY commits CSR writes,
    // VECTOR redirects fetch to the handler, RETURN performs mret/sret.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RETURN = 2'd3
    } trap_state_e;

    // Privilege encodings.
    localparam logic [1:0] MODE_U = 2'd0;
    localparam logic [1:0] MODE_S = 2'd1;
    localparam logic [1:0] MODE_M = 2'd3;

    // Exception cause used for an xret issued from too low a privilege.
    localparam logic [3:0] ILLEGAL_INSN = 4'd2;

endpackage

// File: rtl/rvee_trap_target.sv
// Trap target: picks S or M handler via delegation masks and computes the vector PC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   is_irq, cause    - trap kind and 4-bit cause code
//   mode             - privilege at the time of the trap
//   medeleg, mideleg - exception / interrupt delegation masks
//   mtvec, stvec     - handler base registers
//   to_s             - 1 when the trap is delegated to S-mode
//   vec_pc           - handler entry address
module rvee_trap_target
    import rvee_trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_irq,
    input  logic [3:0]      cause,
    input  logic [1:0]      mode,
    input  logic [15:0]     medeleg,
    input  logic [15:0]     mideleg,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    output logic            to_s,
    output logic [XLEN-1:0] vec_pc
);

    logic            deleg_bit;
    logic [XLEN-1:0] tvec;
    logic [XLEN-1:0] base;

    always_comb begin
        deleg_bit = is_irq ? mideleg[cause] : medeleg[cause];
        // Traps taken in M-mode are never delegated downwards.
        to_s      = (mode != MODE_M) && deleg_bit;
        tvec      = to_s ? stvec : mtvec;
        base      = {tvec[XLEN-1:2], 2'b00};
        // Vectored mode only spreads interrupts; exceptions use the base.
        if (is_irq && (tvec[1:0] == 2'b01)) begin
            vec_pc = base + XLEN'({cause, 2'b00});
        end else begin
            vec_pc = base;
        end
    end

endmodule

// File: rtl/rvee_trap_ctrl.sv
// Trap/xret sequencer: arbitrates exception, interrupt and xret, stacks status, redirects fetch.
// Latency: trap accepted -> ack in 2 cycles (ENTRY, VECTOR); legal xret -> ack in 1 cycle (RETURN).
// Backpressure: requests sampled only in IDLE; requesters hold their level until the ack pulse.
//
// Ports:
//   clk, rst                          - clock, async active-low reset
//   exc_req/cause/tval/pc             - synchronous exception request
//   irq_pending/irq_cause/next_pc     - interrupt request and resume PC
//   xret_req/xret_is_m                - mret (is_m=1) or sret request
//   mode, medeleg, mideleg            - current privilege and delegation masks
//   mtvec, stvec, mepc, sepc, mpp, spp - current CSR values
//   busy, ack                         - sequencer active, request-complete pulse
//   redirect_valid/pc, new_mode       - fetch redirect and privilege to adopt
//   we_trap, trap_to_s, csr_*         - epc/cause/tval write strobe, S/M select, data
//   status_push, status_pop           - trap-entry stacking and xret unstacking of status
module rvee_trap_ctrl
    import rvee_trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_req,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            irq_pending,
    input  logic [3:0]      irq_cause,
    input  logic [XLEN-1:0] next_pc,
    input  logic            xret_req,
    input  logic            xret_is_m,
    input  logic [1:0]      mode,
    input  logic [15:0]     medeleg,
    input  logic [15:0]     mideleg,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic [1:0]      mpp,
    input  logic            spp,
    output logic            busy,
    output logic            ack,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            we_trap,
    output logic            trap_to_s,
    output logic [XLEN-1:0] csr_epc,
    output logic [XLEN-1:0] csr_cause,
    output logic [XLEN-1:0] csr_tval,
    output logic            status_push,
    output logic            status_pop,
    output logic [1:0]      new_mode
);

    trap_state_e     state_q, state_d;
    logic [3:0]      cause_q, cause_d;
    logic            is_irq_q, is_irq_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            to_s_q, to_s_d;
    logic [XLEN-1:0] tgt_pc_q, tgt_pc_d;
    logic [1:0]      tgt_mode_q, tgt_mode_d;

    // Request arbitration (exception > interrupt > xret).
    logic            xret_illegal;
    logic            req_trap;
    logic            req_irq;
    logic            req_ret;
    logic [3:0]      req_cause;
    logic [XLEN-1:0] req_epc;
    logic [XLEN-1:0] req_tval;
    logic            tgt_to_s;
    logic [XLEN-1:0] tgt_pc;

    always_comb begin
        xret_illegal = xret_is_m ? (mode != MODE_M) : (mode == MODE_U);
        req_trap     = 1'b0;
        req_irq      = 1'b0;
        req_ret      = 1'b0;
        req_cause    = '0;
        req_epc      = '0;
        req_tval     = '0;
        if (exc_req) begin
            req_trap  = 1'b1;
            req_cause = exc_cause;
            req_epc   = exc_pc;
            req_tval  = exc_tval;
        end else if (irq_pending) begin
            req_trap  = 1'b1;
            req_irq   = 1'b1;
            req_cause = irq_cause;
            req_epc   = next_pc;
        end else if (xret_req) begin
            if (xret_illegal) begin
                // The xret instruction itself is the faulting PC; tval stays 0.
                req_trap  = 1'b1;
                req_cause = ILLEGAL_INSN;
                req_epc   = exc_pc;
            end else begin
                req_ret   = 1'b1;
            end
        end
    end

    rvee_trap_target #(
        .XLEN (XLEN)
    ) u_target (
        .is_irq  (req_irq),
        .cause   (req_cause),
        .mode    (mode),
        .medeleg (medeleg),
        .mideleg (mideleg),
        .mtvec   (mtvec),
        .stvec   (stvec),
        .to_s    (tgt_to_s),
        .vec_pc  (tgt_pc)
    );

    // Next state, captured request context and outputs.
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        is_irq_d       = is_irq_q;
        epc_d          = epc_q;
        tval_d         = tval_q;
        to_s_d         = to_s_q;
        tgt_pc_d       = tgt_pc_q;
        tgt_mode_d     = tgt_mode_q;

        busy           = 1'b0;
        ack            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        we_trap        = 1'b0;
        trap_to_s      = 1'b0;
        csr_epc        = '0;
        csr_cause      = '0;
        csr_tval       = '0;
        status_push    = 1'b0;
        status_pop     = 1'b0;
        new_mode       = MODE_U;

        unique case (state_q)
            ST_IDLE: begin
                // Everything the later states need is latched here, so the
                // requester's inputs may change freely after acceptance.
                if (req_trap) begin
                    state_d    = ST_ENTRY;
                    cause_d    = req_cause;
                    is_irq_d   = req_irq;
                    epc_d      = req_epc;
                    tval_d     = req_tval;
                    to_s_d     = tgt_to_s;
                    tgt_pc_d   = tgt_pc;
                    tgt_mode_d = tgt_to_s ? MODE_S : MODE_M;
                end else if (req_ret) begin
                    state_d    = ST_RETURN;
                    to_s_d     = ~xret_is_m;
                    tgt_pc_d   = xret_is_m ? mepc : sepc;
                    tgt_mode_d = xret_is_m ? mpp : {1'b0, spp};
                end
            end
            ST_ENTRY: begin
                busy        = 1'b1;
                we_trap     = 1'b1;
                status_push = 1'b1;
                trap_to_s   = to_s_q;
                csr_epc     = epc_q;
                csr_tval    = tval_q;
                csr_cause   = {is_irq_q, {(XLEN-5){1'b0}}, cause_q};
                state_d     = ST_VECTOR;
            end
            ST_VECTOR: begin
                busy           = 1'b1;
                ack            = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = tgt_pc_q;
                new_mode       = tgt_mode_q;
                trap_to_s      = to_s_q;
                state_d        = ST_IDLE;
            end
            ST_RETURN: begin
                // trap_to_s marks sret so the pop targets the S-mode status bits.
                busy           = 1'b1;
                ack            = 1'b1;
                status_pop     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = tgt_pc_q;
                new_mode       = tgt_mode_q;
                trap_to_s      = to_s_q;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            is_irq_q   <= 1'b0;
            epc_q      <= '0;
            tval_q     <= '0;
            to_s_q     <= 1'b0;
            tgt_pc_q   <= '0;
            tgt_mode_q <= MODE_U;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            is_irq_q   <= is_irq_d;
            epc_q      <= epc_d;
            tval_q     <= tval_d;
            to_s_q     <= to_s_d;
            tgt_pc_q   <= tgt_pc_d;
            tgt_mode_q <= tgt_mode_d;
        end
    end

endmodule

// File: tb/tb_rvee_trap_ctrl.sv
// Directed bench for rvee_trap_ctrl: vector table plus hand-written corner sequences.
// Latency: checks exact ENTRY/VECTOR and RETURN cycle placement.
// Backpressure: requests held until ack, then dropped by the bench.
module tb_rvee_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] exc_pc;
    logic        irq_pending;
    logic [3:0]  irq_cause;
    logic [31:0] next_pc;
    logic        xret_req;
    logic        xret_is_m;
    logic [1:0]  mode;
    logic [15:0] medeleg;
    logic [15:0] mideleg;
    logic [31:0] mtvec;
    logic [31:0] stvec;
    logic [31:0] mepc;
    logic [31:0] sepc;
    logic [1:0]  mpp;
    logic        spp;
    logic        busy;
    logic        ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        we_trap;
    logic        trap_to_s;
    logic [31:0] csr_epc;
    logic [31:0] csr_cause;
    logic [31:0] csr_tval;
    logic        status_push;
    logic        status_pop;
    logic [1:0]  new_mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvee_trap_ctrl #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .exc_pc         (exc_pc),
        .irq_pending    (irq_pending),
        .irq_cause      (irq_cause),
        .next_pc        (next_pc),
        .xret_req       (xret_req),
        .xret_is_m      (xret_is_m),
        .mode           (mode),
        .medeleg        (medeleg),
        .mideleg        (mideleg),
        .mtvec          (mtvec),
        .stvec          (stvec),
        .mepc           (mepc),
        .sepc           (sepc),
        .mpp            (mpp),
        .spp            (spp),
        .busy           (busy),
        .ack            (ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .we_trap        (we_trap),
        .trap_to_s      (trap_to_s),
        .csr_epc        (csr_epc),
        .csr_cause      (csr_cause),
        .csr_tval       (csr_tval),
        .status_push    (status_push),
        .status_pop     (status_pop),
        .new_mode       (new_mode)
    );

    // kind: 0 = exception, 1 = interrupt, 2 = mret, 3 = sret
    typedef struct {
        bit [1:0]  kind;
        bit [3:0]  cause;
        bit [31:0] pc;
        bit [31:0] tval;
        bit [1:0]  mode;
        bit [15:0] medeleg;
        bit [15:0] mideleg;
        bit [31:0] mtvec;
        bit [31:0] stvec;
        bit        e_ret;
        bit [31:0] e_cause;
        bit [31:0] e_epc;
        bit [31:0] e_tval;
        bit        e_to_s;
        bit [31:0] e_rpc;
        bit [1:0]  e_mode;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [136:0] all_outs();
        return {busy, ack, redirect_valid, redirect_pc, we_trap, trap_to_s,
                csr_epc, csr_cause, csr_tval, status_push, status_pop, new_mode};
    endfunction

    task automatic clear_reqs();
        exc_req     = 1'b0;
        irq_pending = 1'b0;
        xret_req    = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        exc_req     = (v.kind == 2'd0);
        irq_pending = (v.kind == 2'd1);
        xret_req    = (v.kind >= 2'd2);
        xret_is_m   = (v.kind == 2'd2);
        exc_cause   = v.cause;
        irq_cause   = v.cause;
        exc_pc      = (v.kind == 2'd1) ? 32'hBAD0 : v.pc;
        next_pc     = (v.kind == 2'd1) ? v.pc : 32'hBAD4;
        exc_tval    = v.tval;
        mode        = v.mode;
        medeleg     = v.medeleg;
        mideleg     = v.mideleg;
        mtvec       = v.mtvec;
        stvec       = v.stvec;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        drive_vec(v);
        @(negedge clk);
        if (!v.e_ret) begin
            // ENTRY
            check({t, "_entry_we"}, {we_trap, status_push, busy, ack, redirect_valid}, 5'b11100);
            check({t, "_cause"}, csr_cause, v.e_cause);
            check({t, "_epc"}, csr_epc, v.e_epc);
            check({t, "_tval"}, csr_tval, v.e_tval);
            check({t, "_to_s"}, trap_to_s, v.e_to_s);
            @(negedge clk);
            // VECTOR
            check({t, "_vec_ctl"}, {redirect_valid, ack, busy, we_trap, status_push, status_pop}, 6'b111000);
            check({t, "_rpc"}, redirect_pc, v.e_rpc);
            check({t, "_mode"}, new_mode, v.e_mode);
        end else begin
            // RETURN
            check({t, "_ret_ctl"}, {status_pop, redirect_valid, ack, busy, we_trap, status_push}, 6'b111100);
            check({t, "_rpc"}, redirect_pc, v.e_rpc);
            check({t, "_mode"}, new_mode, v.e_mode);
            check({t, "_to_s"}, trap_to_s, v.e_to_s);
        end
        clear_reqs();
        @(negedge clk);
        check({t, "_idle"}, {busy, ack, redirect_valid}, 3'b000);
    endtask

    initial begin
        //          kind cause  pc            tval          mode  medeleg   mideleg   mtvec         stvec         ret e_cause       e_epc         e_tval     to_s e_rpc        e_mode
        tbl[0] = '{2'd0, 4'd2,  32'h0000_0100, 32'h0000_DEAD, 2'd3, 16'h0000, 16'h0000, 32'h8000_0000, 32'h0000_4001, 1'b0, 32'h0000_0002, 32'h0000_0100, 32'h0000_DEAD, 1'b0, 32'h8000_0000, 2'd3};
        tbl[1] = '{2'd1, 4'd5,  32'h0000_3000, 32'h0000_0077, 2'd0, 16'h0000, 16'h0020, 32'h8000_0001, 32'h0000_4001, 1'b0, 32'h8000_0005, 32'h0000_3000, 32'h0,        1'b1, 32'h0000_4014, 2'd1};
        tbl[2] = '{2'd1, 4'd7,  32'h0000_3100, 32'h0000_0077, 2'd0, 16'h0000, 16'h0020, 32'h8000_0001, 32'h0000_4001, 1'b0, 32'h8000_0007, 32'h0000_3100, 32'h0,        1'b0, 32'h8000_001C, 2'd3};
        tbl[3] = '{2'd0, 4'd8,  32'h0000_0500, 32'h0000_0012, 2'd1, 16'h0100, 16'h0000, 32'h8000_0001, 32'h0000_4001, 1'b0, 32'h0000_0008, 32'h0000_0500, 32'h0000_0012, 1'b1, 32'h0000_4000, 2'd1};
        tbl[4] = '{2'd0, 4'd8,  32'h0000_0504, 32'h0000_0034, 2'd3, 16'h0100, 16'h0000, 32'h8000_0103, 32'h0000_4001, 1'b0, 32'h0000_0008, 32'h0000_0504, 32'h0000_0034, 1'b0, 32'h8000_0100, 2'd3};
        tbl[5] = '{2'd2, 4'd0,  32'h0000_0600, 32'h0000_BEEF, 2'd1, 16'h0000, 16'h0000, 32'h8000_0000, 32'h0000_4001, 1'b0, 32'h0000_0002, 32'h0000_0600, 32'h0,        1'b0, 32'h8000_0000, 2'd3};
        tbl[6] = '{2'd3, 4'd0,  32'h0000_0604, 32'h0000_BEEF, 2'd0, 16'h0004, 16'h0000, 32'h8000_0000, 32'h0000_4005, 1'b0, 32'h0000_0002, 32'h0000_0604, 32'h0,        1'b1, 32'h0000_4004, 2'd1};
        tbl[7] = '{2'd2, 4'd0,  32'h0000_0608, 32'h0,         2'd3, 16'h0000, 16'h0000, 32'h8000_0000, 32'h0000_4001, 1'b1, 32'h0,         32'h0,         32'h0,        1'b0, 32'h0000_0200, 2'd0};
        tbl[8] = '{2'd3, 4'd0,  32'h0000_060C, 32'h0,         2'd1, 16'h0000, 16'h0000, 32'h8000_0000, 32'h0000_4001, 1'b1, 32'h0,         32'h0,         32'h0,        1'b1, 32'h0000_0300, 2'd1};
        tbl[9] = '{2'd1, 4'd11, 32'h0000_3200, 32'h0,         2'd3, 16'h0000, 16'h0800, 32'h8000_0001, 32'h0000_4001, 1'b0, 32'h8000_000B, 32'h0000_3200, 32'h0,        1'b0, 32'h8000_002C, 2'd3};

        rst = 1'b0;
        clear_reqs();
        xret_is_m = 1'b0;
        exc_cause = '0; irq_cause = '0; exc_tval = '0; exc_pc = '0; next_pc = '0;
        mode = 2'd3; medeleg = '0; mideleg = '0; mtvec = '0; stvec = '0;
        mepc = 32'h200; sepc = 32'h300; mpp = 2'd0; spp = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), '0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {busy, ack, we_trap}, 3'b000);

        for (int i = 0; i < NV; i++) run_vec(i, tbl[i]);

        // Captured context: inputs changed right after acceptance must not leak through.
        @(negedge clk);
        drive_vec(tbl[0]);
        @(negedge clk);
        exc_cause = 4'd9; exc_pc = 32'h1111; exc_tval = 32'h2222;
        mode = 2'd0; medeleg = 16'hFFFF; mtvec = 32'h7000_0000;
        #1;
        check("hold_cause", csr_cause, 32'h2);
        check("hold_epc", csr_epc, 32'h100);
        check("hold_tval", csr_tval, 32'hDEAD);
        check("hold_to_s", trap_to_s, 1'b0);
        @(negedge clk);
        check("hold_rpc", {redirect_pc, new_mode}, {32'h8000_0000, 2'd3});
        clear_reqs();
        @(negedge clk);

        // Simultaneous exc + irq + mret: exception first, then irq, then mret.
        exc_req = 1'b1; exc_cause = 4'd4; exc_pc = 32'h700; exc_tval = 32'h44;
        irq_pending = 1'b1; irq_cause = 4'd3; next_pc = 32'h704;
        xret_req = 1'b1; xret_is_m = 1'b1;
        mode = 2'd3; medeleg = '0; mideleg = '0; mtvec = 32'h8000_0001; stvec = 32'h4001;
        @(negedge clk);
        check("prio_exc_cause", {we_trap, csr_cause, csr_epc}, {1'b1, 32'h4, 32'h700});
        @(negedge clk);
        check("prio_exc_ack", {ack, redirect_pc}, {1'b1, 32'h8000_0000});
        exc_req = 1'b0;
        @(negedge clk);
        check("prio_gap_idle", {busy, ack}, 2'b00);
        @(negedge clk);
        check("prio_irq_cause", {we_trap, csr_cause, csr_epc, csr_tval}, {1'b1, 32'h8000_0003, 32'h704, 32'h0});
        @(negedge clk);
        check("prio_irq_ack", {ack, redirect_pc}, {1'b1, 32'h8000_000C});
        irq_pending = 1'b0;
        @(negedge clk);
        check("prio_gap2_idle", {busy, ack}, 2'b00);
        @(negedge clk);
        check("prio_mret", {status_pop, ack, redirect_pc, new_mode}, {1'b1, 1'b1, 32'h200, 2'd0});
        clear_reqs();
        @(negedge clk);

        // Reset asserted during ENTRY forces all outputs low at once.
        drive_vec(tbl[0]);
        @(negedge clk);
        check("rst_pre_entry", we_trap, 1'b1);
        rst = 1'b0;
        clear_reqs();
        #1;
        check("rst_mid_outputs", all_outs(), '0);
        repeat (2) @(negedge clk);
        check("rst_held_outputs", all_outs(), '0);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst_release_c%0d", c), {ack, we_trap, status_push, busy}, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
